// File: rtl/dff_skid_buffer.sv
// Two-entry valid/ready skid buffer. Both handshake outputs and out_data are
// decoded from registered state only, so neither side sees a combinational path.
module dff_skid_buffer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Flush only clears occupancy; the payload registers simply hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (flush) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_fire) begin
               main_d  = in_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (out_fire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = (state_q != FULL);
      out_valid = (state_q != EMPTY);
      count     = state_q;
      out_data  = main_q;
   end

endmodule

// File: doc/dff_skid_buffer.md
# dff_skid_buffer

Two-entry valid/ready pipeline register that sits directly upstream of the `Dff` data registers in hwlib pipelines. It decouples producer and consumer timing so that neither `in_ready` nor `out_data` has a combinational path from the other side. It sustains one transfer per cycle and absorbs one beat of back-pressure (skid) when the consumer stalls.

## Interface
- `WIDTH`, default 1, data width in bits (same meaning as `Dff` `WIDTH`).
- `clk`  in  1  Single clock; all state changes on its rising edge.
- `reset`  in  1  Synchronous, active-high reset, sampled on rising `clk`.
- `flush`  in  1  Synchronous clear of buffered data. Priority below `reset`.
- `in_valid`  in  1  Producer has a beat on `in_data`.
- `in_ready`  out  1  Buffer can accept a beat. Function of state only.
- `in_data`  in  WIDTH  Producer payload.
- `out_valid`  out  1  Beat present on `out_data`. Function of state only.
- `out_ready`  in  1  Consumer accepts a beat.
- `out_data`  out  WIDTH  Payload, driven directly from the main register.
- `count`  out  2  Occupancy: 0, 1 or 2.

## Operation
- Storage: `main` register (feeds `out_data`) and `skid` register, both WIDTH bits.
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- States: EMPTY (count 0), BUSY (count 1, main valid), FULL (count 2, main and skid valid).
- Decoded outputs:
  - `in_ready = (state != FULL)`
  - `out_valid = (state != EMPTY)`
  - `count` = state encoding 0/1/2.
- Transitions, evaluated at each rising edge with no reset or flush active:
  - EMPTY:
    - `in_fire`: main <= in_data; -> BUSY.
    - Otherwise stay.
  - BUSY:
    - `in_fire & out_fire`: main <= in_data; stay BUSY.
    - `in_fire` only: skid <= in_data; -> FULL.
    - `out_fire` only: -> EMPTY.
    - Neither: stay.
  - FULL (in_ready = 0, so no `in_fire` is possible):
    - `out_fire`: main <= skid; -> BUSY.
    - Otherwise stay.
- Ordering: strict FIFO. No beat is dropped, duplicated or reordered except by reset or flush.
- Holding `out_data`: stable while `out_valid=1 & out_ready=0`.
- Inputs while not ready: `in_data` and `in_valid` are ignored whenever `in_ready=0`.
- `flush`: state -> EMPTY. Data registers keep their values (don't-care). Any `in_fire` or `out_fire` in the flush cycle is discarded and counts as not transferred.
- `reset`: state -> EMPTY, main = 0, skid = 0. Overrides `flush` and all handshakes. Valid mid-transfer; buffered beats are lost.

## Timing
- Reset values, visible from the cycle after the reset edge:
  - `in_ready=1`
  - `out_valid=0`
  - `out_data=0`
  - `count=0`
- During `reset=1`, outputs reflect pre-edge state until the first sampled reset edge.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid=1` in the cycle after edge N (1 cycle).
- Throughput: 1 beat/cycle while `out_ready=1`.
- Stall recovery:
  - After the consumer stalls, `in_ready` falls one cycle after the skid fills.
  - `in_ready` rises one cycle after the first `out_fire` from FULL.
- No combinational paths from `out_ready` to `in_ready`, or from `in_valid`/`in_data` to `out_*`.
- Simultaneous `in_fire` and `out_fire` in BUSY: occupancy unchanged; the new beat replaces the departing one in main.

## Test plan
- Reset: hold `reset=1` for 2 edges with `in_valid=1`, `in_data=1` (WIDTH=1), then release -> `out_valid=0`, `out_data=0`, `in_ready=1`, `count=0`; the first accepted beat appears exactly 1 cycle after acceptance.
- Streaming: WIDTH=8, `out_ready=1`, send 0x01..0x10 back-to-back -> output 0x01..0x10 in order, 1 cycle late, no bubbles, `count` stays 1.
- Back-pressure: WIDTH=8, send 0xA1,0xA2,0xA3 with `out_ready=0` -> 0xA1 in main, 0xA2 in skid, `in_ready=0` after the second beat, 0xA3 held by the producer. Then raise `out_ready` -> 0xA1,0xA2,0xA3 in order, `count` 2->1->1->0.
- Simultaneous fire in BUSY: main=0x55, drive `in_data=0x66` with both fires -> next cycle `out_data=0x66`, `count=1`.
- Flush: from FULL (0x11,0x22) assert `flush` together with `in_valid=1`, `in_data=0x33` -> next cycle `count=0`, `out_valid=0`. 0x33 is never delivered and 0x11/0x22 never reappear.
- Reset mid-operation: FULL state with `out_ready` toggling, assert `reset` for 1 edge -> all outputs at reset values next cycle; subsequent beat 0x77 delivered alone.
